// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: producer/consumer bundle for sync_fifo_flags.
// The master drives requests and write data; the slave is the FIFO itself.
interface sync_fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, rd_en, data,
        input  dout, valid, full, empty, almost_full,
        input  almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, data,
        output dout, valid, full, empty, almost_full,
        output almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy, thresholds, error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_flags_if.slave io_fifo
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);
    localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

    generate
        if (WIDTH < 1 || DEPTH < 2) begin : g_bad_size
            $error("sync_fifo_flags: WIDTH or DEPTH out of range");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sync_fifo_flags: AF_THRESH out of range");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_flags: AE_THRESH out of range");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_af;
    logic             r_ae;
    logic             r_ovf;
    logic             r_unf;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [CW-1:0]    w_cnt_nxt;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    // Accept decisions use registered flags; a pop frees a slot when full.
    always_comb begin
        w_rd_acc     = io_fifo.rd_en & ~r_empty;
        w_wr_acc     = io_fifo.wr_en & (~r_full | w_rd_acc);
        w_cnt_nxt    = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
        w_wr_ptr_nxt = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + PW'(1);
        w_rd_ptr_nxt = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + PW'(1);
    end

    // Storage: written only on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= io_fifo.data;
        end
    end

    // Pointers, occupancy, flags (from next count) and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == C_DEPTH);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= C_AF);
            r_ae    <= (w_cnt_nxt <= C_AE);
            r_ovf   <= io_fifo.wr_en & r_full & ~w_rd_acc;
            r_unf   <= io_fifo.rd_en & r_empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally whenever the FIFO holds data.
    always_comb begin
        io_fifo.dout  = r_empty ? '0 : r_mem[r_rd_ptr];
        io_fifo.valid = ~r_empty;
    end
`else
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;

    // Registered read: dout updates only on an accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= r_mem[r_rd_ptr];
            end
        end
    end

    assign io_fifo.dout  = r_dout;
    assign io_fifo.valid = r_valid;
`endif

    assign io_fifo.count        = r_count;
    assign io_fifo.full         = r_full;
    assign io_fifo.empty        = r_empty;
    assign io_fifo.almost_full  = r_af;
    assign io_fifo.almost_empty = r_ae;
    assign io_fifo.overflow     = r_ovf;
    assign io_fifo.underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: scoreboard bench for sync_fifo_flags.
// Two instances (DEPTH 16 and 6) share stimulus through a select bit.
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = 8'h00;
    bit         sel = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    int         mc = 0;
    logic [7:0] last_dout = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) bus16 ();
    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(6))  bus6 ();

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16)) u_dut16 (
        .clk     (clk),
        .rst     (rst),
        .io_fifo (bus16.slave)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(6)) u_dut6 (
        .clk     (clk),
        .rst     (rst),
        .io_fifo (bus6.slave)
    );

    assign bus16.wr_en = wr & ~sel;
    assign bus16.rd_en = rd & ~sel;
    assign bus16.data  = din;
    assign bus6.wr_en  = wr & sel;
    assign bus6.rd_en  = rd & sel;
    assign bus6.data   = din;

    logic [7:0] o_dout;
    logic [4:0] o_count;
    logic o_valid, o_full, o_empty, o_af, o_ae, o_ovf, o_unf;

    assign o_dout  = sel ? bus6.dout : bus16.dout;
    assign o_count = sel ? {2'b00, bus6.count} : bus16.count;
    assign o_valid = sel ? bus6.valid : bus16.valid;
    assign o_full  = sel ? bus6.full : bus16.full;
    assign o_empty = sel ? bus6.empty : bus16.empty;
    assign o_af    = sel ? bus6.almost_full : bus16.almost_full;
    assign o_ae    = sel ? bus6.almost_empty : bus16.almost_empty;
    assign o_ovf   = sel ? bus6.overflow : bus16.overflow;
    assign o_unf   = sel ? bus6.underflow : bus16.underflow;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks everything that must hold right after reset.
    task automatic chk_reset_state();
        chk("rst_count", 32'(o_count), 0);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_ae", 32'(o_ae), 1);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_af", 32'(o_af), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_dout", 32'(o_dout), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        chk("rst_unf", 32'(o_unf), 0);
    endtask

    // Pulse reset between clock edges and check the async clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        sb.delete();
        mc = 0;
        last_dout = 8'h00;
        chk_reset_state();
        #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus with a full model check afterwards.
    task automatic cyc(input bit w, input bit r, input logic [7:0] d);
        int         dep;
        bit         racc, wacc, ovf, unf;
        logic [7:0] exp;
        dep  = sel ? 6 : 16;
        racc = r && (mc > 0);
        wacc = w && ((mc < dep) || racc);
        ovf  = w && (mc == dep) && !racc;
        unf  = r && (mc == 0);
        exp  = 8'h00;
        wr = w;
        rd = r;
        din = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        if (racc) exp = sb.pop_front();
        if (wacc) sb.push_back(d);
        mc = mc + int'(wacc) - int'(racc);
        chk("count", 32'(o_count), 32'(mc));
        chk("full", 32'(o_full), 32'(mc == dep));
        chk("empty", 32'(o_empty), 32'(mc == 0));
        chk("almost_full", 32'(o_af), 32'(mc >= dep - 2));
        chk("almost_empty", 32'(o_ae), 32'(mc <= 2));
        chk("overflow", 32'(o_ovf), 32'(ovf));
        chk("underflow", 32'(o_unf), 32'(unf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("valid", 32'(o_valid), 32'(mc != 0));
        if (mc != 0) chk("dout_head", 32'(o_dout), 32'(sb[0]));
        else         chk("dout_idle", 32'(o_dout), 0);
`else
        chk("valid", 32'(o_valid), 32'(racc));
        if (racc) last_dout = exp;
        chk("dout", 32'(o_dout), 32'(last_dout));
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Fill to full, then one overflowing write.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b0, 1'b0, 8'h00);

        // Drain completely, then one underflowing read.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        // Simultaneous read and write while full.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(100 + i));
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);

        // Simultaneous read and write while empty.
        cyc(1'b1, 1'b1, 8'h77);
        cyc(1'b0, 1'b1, 8'h00);

        // Wrap-around on the DEPTH=6 instance.
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k += 3) begin
            int n;
            n = (10 - k < 3) ? 10 - k : 3;
            for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'(8'h30 + k + i));
            for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'h00);

        // Reset in the middle of operation.
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hE0 + i));
        #2;
        do_reset();
        cyc(1'b1, 1'b0, 8'h55);
        cyc(1'b0, 1'b1, 8'h00);

        // Single word into empty, then pop.
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
